// File: rtl/hpdcache_1hot_to_binary.sv
// One-hot to binary index converter; outputs 0 for an all-zero input.
module hpdcache_1hot_to_binary #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  val_i,
    output logic [IW-1:0] val_o
);

    // OR together the indices of all set bits (exactly one for valid input)
    always_comb begin
        val_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (val_i[i]) begin
                val_o = val_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Lowest-index-first priority encoder: returns a one-hot0 vector selecting
// the lowest set bit of val_i (all zeros when val_i is zero).
module hpdcache_prio_1hot_encoder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    logic found;

    // Keep only the first set bit scanning from index 0 upward
    always_comb begin
        val_o = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (val_i[i] && !found) begin
                val_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpdcache_wrrarb.sv
// Weighted round-robin arbiter. Each requester may hold the grant for up to
// max(weight,1) consecutive accepted transfers before priority rotates.
// A grant offered while ready_i is low is frozen until accepted.
// Optional macro HPDCACHE_WRRARB_ASSERT_EN enables protocol/state assertions.
module hpdcache_wrrarb #(
    parameter int unsigned N  = 4,
    parameter int unsigned WW = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N-1:0]                         req_i,
    input  logic [N*WW-1:0]                      weight_i,
    output logic [N-1:0]                         gnt_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx_o,
    input  logic                                 ready_i
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] GNT_RST = N'(1) << (N - 1);

    logic [N-1:0]  gnt_q, gnt_d;
    logic          wait_q, wait_d;
    logic          stay_q, stay_d;
    logic [WW-1:0] credit_q, credit_d;

    logic [N-1:0]  nxt, mask, req_masked;
    logic [N-1:0]  rot_masked, rot_unmasked, rot, gnt;
    logic          pending, stay, sel_stay, accept;
    logic [WW-1:0] w_sel, reload;

    // Priority mask: requesters strictly after the current owner, wrapping
    always_comb begin
        nxt  = '0;
        mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            nxt[(i + 1) % int'(N)] = gnt_q[i];
        end
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (i == 0) ? nxt[0] : (mask[i-1] | nxt[i]);
        end
        req_masked = req_i & mask;
    end

    hpdcache_prio_1hot_encoder #(.N(N)) u_prio_masked (
        .val_i (req_masked),
        .val_o (rot_masked)
    );

    hpdcache_prio_1hot_encoder #(.N(N)) u_prio_unmasked (
        .val_i (req_i),
        .val_o (rot_unmasked)
    );

    hpdcache_1hot_to_binary #(.N(N), .IW(IW)) u_idx (
        .val_i (gnt_o),
        .val_o (gnt_idx_o)
    );

    // Grant selection, credit bookkeeping and next-state computation
    always_comb begin
        pending  = |req_i;
        stay     = (|(req_i & gnt_q)) & (credit_q != '0);
        rot      = (|rot_masked) ? rot_masked : rot_unmasked;
        gnt      = stay ? gnt_q : rot;
        gnt_o    = wait_q ? gnt_q : gnt;
        sel_stay = wait_q ? stay_q : stay;
        accept   = (|gnt_o) & ready_i;

        // Weight of whoever is shown on gnt_o; weight 0 behaves as 1
        w_sel = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (gnt_o[k]) begin
                w_sel = weight_i[k*WW +: WW];
            end
        end
        reload = (w_sel == '0) ? '0 : (w_sel - WW'(1));

        wait_d   = ~ready_i & (wait_q | pending);
        gnt_d    = gnt_q;
        stay_d   = wait_q ? stay_q : stay;
        credit_d = credit_q;
        if (!wait_q && pending) begin
            gnt_d = gnt;
        end
        if (accept) begin
            credit_d = sel_stay ? (credit_q - WW'(1)) : reload;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q    <= GNT_RST;
            wait_q   <= 1'b0;
            stay_q   <= 1'b0;
            credit_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            wait_q   <= wait_d;
            stay_q   <= stay_d;
            credit_q <= credit_d;
        end
    end

`ifdef HPDCACHE_WRRARB_ASSERT_EN
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_gnt_q_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot(gnt_q));
    a_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        wait_q |-> |(req_i & gnt_q));
    a_gnt_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        wait_q |-> $stable(gnt_o));
    a_credit_reload : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (accept && !sel_stay) |=> (credit_q <= $past(reload)));
`endif

endmodule

// File: tb/tb_hpdcache_wrrarb.sv
// Directed bench for hpdcache_wrrarb (N=4, WW=4) with an expected-grant queue.
module tb_hpdcache_wrrarb;

    localparam int unsigned N  = 4;
    localparam int unsigned WW = 4;

    logic          clk_i;
    logic          rst_ni;
    logic [N-1:0]  req_i;
    logic [N*WW-1:0] weight_i;
    logic [N-1:0]  gnt_o;
    logic [1:0]    gnt_idx_o;
    logic          ready_i;

    int checks;
    int passed;
    logic [N-1:0] exp_q[$];

    hpdcache_wrrarb #(.N(N), .WW(WW)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .weight_i  (weight_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .ready_i   (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [N*WW-1:0] wpack(input int w0, input int w1,
                                              input int w2, input int w3);
        return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endfunction

    function automatic logic [1:0] idx_of(input logic [N-1:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Pop the oldest expectation and compare both grant outputs
    task automatic check_out(input string tag);
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL %s: scoreboard empty, observed gnt=%b", tag, gnt_o);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (gnt_o === e) passed++;
        else $error("FAIL %s gnt_o: observed %b expected %b", tag, gnt_o, e);
        checks++;
        assert (gnt_idx_o === idx_of(e)) passed++;
        else $error("FAIL %s gnt_idx_o: observed %0d expected %0d", tag, gnt_idx_o, idx_of(e));
    endtask

    // Drive one cycle of stimulus on the falling edge and check before the rise
    task automatic cyc(input string tag, input logic [N-1:0] req,
                       input logic rdy, input logic [N-1:0] exp);
        @(negedge clk_i);
        req_i   = req;
        ready_i = rdy;
        exp_q.push_back(exp);
        #2;
        check_out(tag);
    endtask

    task automatic do_reset(input logic [N*WW-1:0] w);
        @(negedge clk_i);
        rst_ni   = 1'b0;
        req_i    = '0;
        ready_i  = 1'b0;
        weight_i = w;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        rst_ni   = 1'b0;
        req_i    = '0;
        ready_i  = 1'b0;
        weight_i = wpack(1, 1, 1, 1);

        // Reset state: no request means no grant
        #2;
        exp_q.push_back(4'b0000);
        check_out("reset");

        // Weighted rotation 1,2,3,1
        do_reset(wpack(1, 2, 3, 1));
        cyc("wrr0", 4'b1111, 1'b1, 4'b0001);
        cyc("wrr1", 4'b1111, 1'b1, 4'b0010);
        cyc("wrr2", 4'b1111, 1'b1, 4'b0010);
        cyc("wrr3", 4'b1111, 1'b1, 4'b0100);
        cyc("wrr4", 4'b1111, 1'b1, 4'b0100);
        cyc("wrr5", 4'b1111, 1'b1, 4'b0100);
        cyc("wrr6", 4'b1111, 1'b1, 4'b1000);
        cyc("wrr7", 4'b1111, 1'b1, 4'b0001);
        cyc("wrr8", 4'b1111, 1'b1, 4'b0010);
        cyc("wrr9", 4'b1111, 1'b1, 4'b0010);

        // Sparse requests with unit weights
        do_reset(wpack(1, 1, 1, 1));
        cyc("sparse0", 4'b1010, 1'b1, 4'b0010);
        cyc("sparse1", 4'b1010, 1'b1, 4'b1000);
        cyc("sparse2", 4'b1010, 1'b1, 4'b0010);

        // Frozen grant: credit applied exactly once on acceptance
        do_reset(wpack(2, 1, 1, 1));
        cyc("hold0", 4'b0001, 1'b0, 4'b0001);
        cyc("hold1", 4'b0111, 1'b0, 4'b0001);
        cyc("hold2", 4'b0111, 1'b0, 4'b0001);
        cyc("hold3", 4'b0111, 1'b1, 4'b0001);
        cyc("hold4", 4'b0111, 1'b1, 4'b0001);
        cyc("hold5", 4'b0111, 1'b1, 4'b0010);
        cyc("hold6", 4'b0111, 1'b1, 4'b0100);

        // Owner leaves with credit; rejoins with full credit
        do_reset(wpack(1, 3, 1, 1));
        cyc("drop0", 4'b0010, 1'b1, 4'b0010);
        cyc("drop1", 4'b1000, 1'b1, 4'b1000);
        cyc("drop2", 4'b1010, 1'b1, 4'b0010);
        cyc("drop3", 4'b1010, 1'b1, 4'b0010);
        cyc("drop4", 4'b1010, 1'b1, 4'b0010);
        cyc("drop5", 4'b1010, 1'b1, 4'b1000);

        // Weight 0 behaves as weight 1
        do_reset(wpack(1, 1, 0, 1));
        cyc("w0_0", 4'b0101, 1'b1, 4'b0001);
        cyc("w0_1", 4'b0101, 1'b1, 4'b0100);
        cyc("w0_2", 4'b0101, 1'b1, 4'b0001);
        cyc("w0_3", 4'b0101, 1'b1, 4'b0100);
        cyc("w0_4", 4'b0101, 1'b1, 4'b0001);

        // Asynchronous reset while a stay grant is frozen
        do_reset(wpack(3, 1, 1, 1));
        cyc("rstw0", 4'b0001, 1'b1, 4'b0001);
        cyc("rstw1", 4'b0011, 1'b0, 4'b0001);
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i  = '0;
        exp_q.push_back(4'b0000);
        #2;
        check_out("rstw_in_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc("rstw2", 4'b1111, 1'b1, 4'b0001);
        cyc("rstw3", 4'b1111, 1'b1, 4'b0001);
        cyc("rstw4", 4'b1111, 1'b1, 4'b0001);
        cyc("rstw5", 4'b1111, 1'b1, 4'b0010);

        checks++;
        assert (exp_q.size() == 0) passed++;
        else $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
